// File: rtl/evt_time_unit_mc.sv
//==============================================================================
// Module   : evt_time_unit_mc
// Brief    : Forks time/synch events to N_CH channels and commits TIME stamps
//            into a global time register with wrap (epoch) tracking.
//            Optional dispatch watchdog: define SNE_TIME_UNIT_WATCHDOG_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module evt_time_unit_mc #(
    parameter int              N_CH        = 4,
    parameter int              TS_W        = 32,
    parameter int              OP_W        = 4,
    parameter logic [OP_W-1:0] OP_TIME     = 4'h1,
    parameter logic [OP_W-1:0] OP_SYNCH    = 4'h2,
    parameter int              EPOCH_W     = 8,
    parameter int              TIMEOUT_CYC = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               evt_valid_i,
    output logic               evt_ready_o,
    input  logic [OP_W-1:0]    evt_op_i,
    input  logic [TS_W-1:0]    evt_ts_i,
    input  logic [N_CH-1:0]    synch_mask_i,
    input  logic               hold_i,
    output logic [N_CH-1:0]    ch_valid_o,
    input  logic [N_CH-1:0]    ch_ready_i,
    output logic [OP_W-1:0]    ch_op_o,
    output logic [TS_W-1:0]    ch_ts_o,
    output logic [TS_W-1:0]    global_time_o,
    output logic [EPOCH_W-1:0] global_epoch_o,
    output logic               time_stable_o,
    output logic               err_timeout_o
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        DISPATCH = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 ready_q, ready_d;
    logic [OP_W-1:0]      op_q, op_d;
    logic [TS_W-1:0]      ts_q, ts_d;
    logic [N_CH-1:0]      pend_q, pend_d;
    logic                 commit_pend_q, commit_pend_d;
    logic [TS_W-1:0]      gtime_q, gtime_d;
    logic [EPOCH_W-1:0]   epoch_q, epoch_d;
    logic                 stable_q, stable_d;

    logic [N_CH-1:0]      hs;
    logic                 wd_fire;

    assign hs = pend_q & ch_ready_i;

`ifdef SNE_TIME_UNIT_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             err_q, err_d;

    // Counts consecutive handshake-free cycles while deliveries are outstanding.
    always_comb begin
        wd_cnt_d = '0;
        wd_fire  = 1'b0;
        err_d    = err_q;
        if (state_q == DISPATCH && pend_q != '0) begin
            if (|hs) begin
                wd_cnt_d = '0;
            end else if (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                wd_fire = 1'b1;
                err_d   = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_timeout_o = err_q;
`else
    assign wd_fire       = 1'b0;
    // Without the watchdog the error can never be raised.
    assign err_timeout_o = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        ts_d          = ts_q;
        pend_d        = pend_q;
        commit_pend_d = commit_pend_q;
        gtime_d       = gtime_q;
        epoch_d       = epoch_q;
        stable_d      = stable_q;

        case (state_q)
            IDLE: begin
                if (evt_valid_i && ready_q) begin
                    op_d          = evt_op_i;
                    ts_d          = evt_ts_i;
                    pend_d        = (evt_op_i == OP_SYNCH) ? synch_mask_i : '1;
                    commit_pend_d = (evt_op_i == OP_TIME);
                    if (evt_op_i == OP_TIME) begin
                        stable_d = 1'b0;
                    end
                    state_d = DISPATCH;
                end
            end
            DISPATCH: begin
                pend_d = wd_fire ? '0 : (pend_q & ~ch_ready_i);
                if (commit_pend_q && !hold_i) begin
                    gtime_d       = ts_q;
                    commit_pend_d = 1'b0;
                    // A strictly smaller stamp means the timestamp counter wrapped.
                    if (ts_q < gtime_q) begin
                        epoch_d = epoch_q + 1'b1;
                    end
                end
                if (pend_d == '0 && !commit_pend_d) begin
                    state_d  = IDLE;
                    stable_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            ready_q       <= 1'b0;
            op_q          <= '0;
            ts_q          <= '0;
            pend_q        <= '0;
            commit_pend_q <= 1'b0;
            gtime_q       <= '0;
            epoch_q       <= '0;
            stable_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            op_q          <= op_d;
            ts_q          <= ts_d;
            pend_q        <= pend_d;
            commit_pend_q <= commit_pend_d;
            gtime_q       <= gtime_d;
            epoch_q       <= epoch_d;
            stable_q      <= stable_d;
        end
    end

    assign evt_ready_o    = ready_q;
    assign ch_valid_o     = pend_q;
    assign ch_op_o        = op_q;
    assign ch_ts_o        = ts_q;
    assign global_time_o  = gtime_q;
    assign global_epoch_o = epoch_q;
    assign time_stable_o  = stable_q;

endmodule

`default_nettype wire

// File: tb/tb_evt_time_unit_mc.sv
//==============================================================================
// Module   : tb_evt_time_unit_mc
// Brief    : Scoreboard bench for evt_time_unit_mc (channel deliveries queued
//            per channel at acceptance, popped on each channel handshake).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_evt_time_unit_mc;

    localparam int N_CH    = 4;
    localparam int TS_W    = 32;
    localparam int OP_W    = 4;
    localparam int EPOCH_W = 8;
`ifdef SNE_TIME_UNIT_WATCHDOG_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 256;
`endif
    localparam logic [OP_W-1:0] C_OP_TIME  = 4'h1;
    localparam logic [OP_W-1:0] C_OP_SYNCH = 4'h2;

    logic               clk;
    logic               rst_i;
    logic               evt_valid_i;
    logic               evt_ready_o;
    logic [OP_W-1:0]    evt_op_i;
    logic [TS_W-1:0]    evt_ts_i;
    logic [N_CH-1:0]    synch_mask_i;
    logic               hold_i;
    logic [N_CH-1:0]    ch_valid_o;
    logic [N_CH-1:0]    ch_ready_i;
    logic [OP_W-1:0]    ch_op_o;
    logic [TS_W-1:0]    ch_ts_o;
    logic [TS_W-1:0]    global_time_o;
    logic [EPOCH_W-1:0] global_epoch_o;
    logic               time_stable_o;
    logic               err_timeout_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int accept_cyc = 0;

    logic [OP_W+TS_W-1:0] exp_q [N_CH][$];
    logic [N_CH-1:0]      prev_v = '0;
    logic [OP_W-1:0]      prev_op = '0;
    logic [TS_W-1:0]      prev_ts = '0;

    evt_time_unit_mc #(
        .N_CH        (N_CH),
        .TS_W        (TS_W),
        .OP_W        (OP_W),
        .OP_TIME     (C_OP_TIME),
        .OP_SYNCH    (C_OP_SYNCH),
        .EPOCH_W     (EPOCH_W),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .evt_valid_i    (evt_valid_i),
        .evt_ready_o    (evt_ready_o),
        .evt_op_i       (evt_op_i),
        .evt_ts_i       (evt_ts_i),
        .synch_mask_i   (synch_mask_i),
        .hold_i         (hold_i),
        .ch_valid_o     (ch_valid_o),
        .ch_ready_i     (ch_ready_i),
        .ch_op_o        (ch_op_o),
        .ch_ts_o        (ch_ts_o),
        .global_time_o  (global_time_o),
        .global_epoch_o (global_epoch_o),
        .time_stable_o  (time_stable_o),
        .err_timeout_o  (err_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Channel monitor: holds valid data stable and matches deliveries in order.
    always @(negedge clk) begin
        if (rst_i) begin
            prev_v = '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (prev_v[i] && !err_timeout_o) begin
                    checks++;
                    if (ch_valid_o[i] !== 1'b1 || ch_op_o !== prev_op || ch_ts_o !== prev_ts) begin
                        errors++;
                        $display("FAIL ch%0d_stable: got v=%b op=%0h ts=%0h required v=1 op=%0h ts=%0h",
                                 i, ch_valid_o[i], ch_op_o, ch_ts_o, prev_op, prev_ts);
                    end
                end
                if (ch_valid_o[i] && ch_ready_i[i]) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL ch%0d_unexpected: got op=%0h ts=%0h required no delivery",
                                 i, ch_op_o, ch_ts_o);
                    end else begin
                        logic [OP_W+TS_W-1:0] e;
                        e = exp_q[i].pop_front();
                        if ({ch_op_o, ch_ts_o} !== e) begin
                            errors++;
                            $display("FAIL ch%0d_data: got %0h required %0h", i, {ch_op_o, ch_ts_o}, e);
                        end
                    end
                end
            end
            prev_v  = ch_valid_o & ~ch_ready_i;
            prev_op = ch_op_o;
            prev_ts = ch_ts_o;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_q();
        for (int i = 0; i < N_CH; i++) exp_q[i].delete();
    endtask

    // Presents one event and records the deliveries it must produce.
    task automatic send_evt(input logic [OP_W-1:0] op, input logic [TS_W-1:0] ts,
                            input logic [N_CH-1:0] mask);
        logic [N_CH-1:0] eff;
        bit done;
        done         = 1'b0;
        evt_valid_i  = 1'b1;
        evt_op_i     = op;
        evt_ts_i     = ts;
        synch_mask_i = mask;
        eff = (op == C_OP_SYNCH) ? mask : '1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (evt_ready_o === 1'b1) begin
                for (int i = 0; i < N_CH; i++) if (eff[i]) exp_q[i].push_back({op, ts});
                accept_cyc = cyc;
                done = 1'b1;
            end
            next_cycle();
        end
        evt_valid_i = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept required accept of op=%0h", op);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (evt_ready_o === 1'b1) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got ready=0 required ready=1");
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if ({evt_ready_o, ch_valid_o, ch_op_o, ch_ts_o, global_time_o, global_epoch_o,
             time_stable_o, err_timeout_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b op=%0h ts=%0h gt=%0h ep=%0h st=%b err=%b required all 0",
                     evt_ready_o, ch_valid_o, ch_op_o, ch_ts_o, global_time_o, global_epoch_o,
                     time_stable_o, err_timeout_o);
        end
        next_cycle();
        rst_i = 1'b0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        checks++;
        if (evt_ready_o !== 1'b1 || time_stable_o !== 1'b0 || ch_valid_o !== '0 || global_time_o !== '0) begin
            errors++;
            $display("FAIL reset_idle: got rdy=%b st=%b v=%b gt=%0h required rdy=1 st=0 v=0 gt=0",
                     evt_ready_o, time_stable_o, ch_valid_o, global_time_o);
        end
        next_cycle();
    endtask

    task automatic test_time_basic();
        ch_ready_i = 4'b1111;
        hold_i     = 1'b0;
        send_evt(C_OP_TIME, 32'h100, 4'b0000);
        @(negedge clk);
        checks++;
        if (ch_valid_o !== 4'b1111 || time_stable_o !== 1'b0 || evt_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL time_t1: got v=%b st=%b rdy=%b required v=1111 st=0 rdy=0",
                     ch_valid_o, time_stable_o, evt_ready_o);
        end
        @(negedge clk);
        checks++;
        if (global_time_o !== 32'h100 || time_stable_o !== 1'b1 || evt_ready_o !== 1'b1 ||
            global_epoch_o !== 8'd0) begin
            errors++;
            $display("FAIL time_t2: got gt=%0h st=%b rdy=%b ep=%0d required gt=100 st=1 rdy=1 ep=0",
                     global_time_o, time_stable_o, evt_ready_o, global_epoch_o);
        end
        next_cycle();
    endtask

    task automatic test_synch();
        send_evt(C_OP_SYNCH, 32'h55, 4'b1000);
        @(negedge clk);
        checks++;
        if (ch_valid_o !== 4'b1000 || global_time_o !== 32'h100) begin
            errors++;
            $display("FAIL synch_mask: got v=%b gt=%0h required v=1000 gt=100", ch_valid_o, global_time_o);
        end
        @(negedge clk);
        checks++;
        if (evt_ready_o !== 1'b1 || global_time_o !== 32'h100 || time_stable_o !== 1'b1) begin
            errors++;
            $display("FAIL synch_done: got rdy=%b gt=%0h st=%b required rdy=1 gt=100 st=1",
                     evt_ready_o, global_time_o, time_stable_o);
        end
        next_cycle();
        send_evt(C_OP_SYNCH, 32'h66, 4'b0000);
        @(negedge clk);
        checks++;
        if (ch_valid_o !== 4'b0000 || evt_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL synch_empty: got v=%b rdy=%b required v=0000 rdy=0", ch_valid_o, evt_ready_o);
        end
        @(negedge clk);
        checks++;
        if (evt_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL synch_empty_done: got rdy=%b required 1", evt_ready_o);
        end
        next_cycle();
    endtask

    task automatic test_other_op();
        send_evt(4'h7, 32'h777, 4'b0101);
        @(negedge clk);
        checks++;
        if (ch_valid_o !== 4'b1111) begin
            errors++;
            $display("FAIL other_fork: got v=%b required 1111", ch_valid_o);
        end
        @(negedge clk);
        checks++;
        if (evt_ready_o !== 1'b1 || global_time_o !== 32'h100 || time_stable_o !== 1'b1) begin
            errors++;
            $display("FAIL other_nocommit: got rdy=%b gt=%0h st=%b required rdy=1 gt=100 st=1",
                     evt_ready_o, global_time_o, time_stable_o);
        end
        next_cycle();
    endtask

    task automatic test_stagger();
        logic [N_CH-1:0] exp_v;
        ch_ready_i = 4'b0000;
        hold_i     = 1'b1;
        send_evt(C_OP_TIME, 32'h200, 4'b0000);
        for (int k = 1; k <= 8; k++) begin
            ch_ready_i[0] = (k == 1);
            ch_ready_i[2] = (k == 3);
            ch_ready_i[1] = (k == 5);
            ch_ready_i[3] = (k == 5);
            hold_i        = (k < 7);
            exp_v = (k == 1) ? 4'b1111 : (k <= 3) ? 4'b1110 : (k <= 5) ? 4'b1010 : 4'b0000;
            @(negedge clk);
            checks++;
            if (ch_valid_o !== exp_v) begin
                errors++;
                $display("FAIL stagger_valid k=%0d: got %b required %b", k, ch_valid_o, exp_v);
            end
            checks++;
            if (evt_ready_o !== (k == 8) || time_stable_o !== (k == 8) ||
                global_time_o !== ((k == 8) ? 32'h200 : 32'h100)) begin
                errors++;
                $display("FAIL stagger_commit k=%0d: got rdy=%b st=%b gt=%0h required rdy=%b st=%b gt=%0h",
                         k, evt_ready_o, time_stable_o, global_time_o, (k == 8), (k == 8),
                         (k == 8) ? 32'h200 : 32'h100);
            end
            next_cycle();
        end
        ch_ready_i = 4'b1111;
        hold_i     = 1'b0;
    endtask

    task automatic test_wrap();
        send_evt(C_OP_TIME, 32'hFFFF_FFF0, 4'b0000);
        wait_idle();
        checks++;
        if (global_time_o !== 32'hFFFF_FFF0 || global_epoch_o !== 8'd0) begin
            errors++;
            $display("FAIL wrap_pre: got gt=%0h ep=%0d required gt=fffffff0 ep=0", global_time_o, global_epoch_o);
        end
        next_cycle();
        send_evt(C_OP_TIME, 32'h10, 4'b0000);
        wait_idle();
        checks++;
        if (global_time_o !== 32'h10 || global_epoch_o !== 8'd1) begin
            errors++;
            $display("FAIL wrap_inc: got gt=%0h ep=%0d required gt=10 ep=1", global_time_o, global_epoch_o);
        end
        next_cycle();
        send_evt(C_OP_TIME, 32'h10, 4'b0000);
        wait_idle();
        checks++;
        if (global_time_o !== 32'h10 || global_epoch_o !== 8'd1) begin
            errors++;
            $display("FAIL wrap_equal: got gt=%0h ep=%0d required gt=10 ep=1", global_time_o, global_epoch_o);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int a;
        send_evt(C_OP_TIME, 32'h20, 4'b0000);
        a = accept_cyc;
        send_evt(C_OP_TIME, 32'h30, 4'b0000);
        checks++;
        if (accept_cyc - a !== 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles required 2", accept_cyc - a);
        end
        wait_idle();
        checks++;
        if (global_time_o !== 32'h30 || global_epoch_o !== 8'd1) begin
            errors++;
            $display("FAIL b2b_commit: got gt=%0h ep=%0d required gt=30 ep=1", global_time_o, global_epoch_o);
        end
        next_cycle();
    endtask

`ifdef SNE_TIME_UNIT_WATCHDOG_EN
    task automatic test_watchdog();
        int first_k;
        first_k    = 0;
        ch_ready_i = 4'b1101;
        send_evt(C_OP_TIME, 32'h400, 4'b0000);
        for (int k = 1; k <= 20 && first_k == 0; k++) begin
            @(negedge clk);
            if (err_timeout_o === 1'b1) first_k = k;
        end
        checks++;
        if (first_k !== 10) begin
            errors++;
            $display("FAIL wd_latency: got err at k=%0d required k=10", first_k);
        end
        checks++;
        if (ch_valid_o !== 4'b0000 || evt_ready_o !== 1'b1 || global_time_o !== 32'h400) begin
            errors++;
            $display("FAIL wd_drop: got v=%b rdy=%b gt=%0h required v=0000 rdy=1 gt=400",
                     ch_valid_o, evt_ready_o, global_time_o);
        end
        checks++;
        if (exp_q[1].size() !== 1) begin
            errors++;
            $display("FAIL wd_ch1_pending: got %0d queued required 1", exp_q[1].size());
        end
        exp_q[1].delete();
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (err_timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL wd_sticky: got %b required 1", err_timeout_o);
        end
        next_cycle();
        ch_ready_i = 4'b1111;
    endtask
`endif

    task automatic test_reset_mid();
        hold_i     = 1'b1;
        ch_ready_i = 4'b0000;
        send_evt(C_OP_TIME, 32'h300, 4'b0000);
        @(negedge clk);
        checks++;
        if (ch_valid_o !== 4'b1111) begin
            errors++;
            $display("FAIL mid_inflight: got v=%b required 1111", ch_valid_o);
        end
        next_cycle();
        rst_i = 1'b1;
        flush_q();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({evt_ready_o, ch_valid_o, ch_op_o, ch_ts_o, global_time_o, global_epoch_o,
             time_stable_o, err_timeout_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got rdy=%b v=%b op=%0h ts=%0h gt=%0h ep=%0h st=%b err=%b required all 0",
                     evt_ready_o, ch_valid_o, ch_op_o, ch_ts_o, global_time_o, global_epoch_o,
                     time_stable_o, err_timeout_o);
        end
        next_cycle();
        rst_i      = 1'b0;
        hold_i     = 1'b0;
        ch_ready_i = 4'b1111;
        repeat (4) next_cycle();
        @(negedge clk);
        checks++;
        if (global_time_o !== '0 || time_stable_o !== 1'b0 || ch_valid_o !== '0 ||
            evt_ready_o !== 1'b1 || global_epoch_o !== '0 || err_timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_nocommit: got gt=%0h st=%b v=%b rdy=%b ep=%0d err=%b required gt=0 st=0 v=0 rdy=1 ep=0 err=0",
                     global_time_o, time_stable_o, ch_valid_o, evt_ready_o, global_epoch_o, err_timeout_o);
        end
        next_cycle();
    endtask

    initial begin
        rst_i        = 1'b1;
        evt_valid_i  = 1'b0;
        evt_op_i     = '0;
        evt_ts_i     = '0;
        synch_mask_i = '0;
        hold_i       = 1'b0;
        ch_ready_i   = '0;

        test_reset();
        test_time_basic();
        test_synch();
        test_other_op();
        test_stagger();
        test_wrap();
        test_back_to_back();
`ifdef SNE_TIME_UNIT_WATCHDOG_EN
        test_watchdog();
`endif
        test_reset_mid();

        for (int i = 0; i < N_CH; i++) begin
            checks++;
            if (exp_q[i].size() !== 0) begin
                errors++;
                $display("FAIL ch%0d_leftover: got %0d undelivered required 0", i, exp_q[i].size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
